rtm8sfp_serial_regs: RTL and testbench

Serial shift-register bridge for the 8-SFP rear transition module. It continuously refreshes the module's control register (TX disable, rate selects, LEDs) from parallel FPGA inputs. In the same serial frame it reads back the module's status register (LOS, TX fault, presence, LED1). It sits between the FOFB controller's SFP management logic and the RTM's shift-register chains.

---
 rtl/rtm8sfp_serial_regs_pkg.sv | 18 +
 rtl/rtm8sfp_serial_regs_serial_tick_gen.sv | 26 ++
 rtl/rtm8sfp_serial_regs.sv | 169 ++++++++++++++++
 tb/tb_rtm8sfp_serial_regs.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtm8sfp_serial_regs_pkg.sv
// Shared constants and FSM state type for the RTM 8-SFP serial register bridge.
package rtm8sfp_serial_regs_pkg;

  localparam int N_SFP        = 8;
  localparam int CTL_BITS     = 40;
  localparam int STA_BITS     = 32;
  localparam int SHIFT_HALVES = 2 * CTL_BITS;
  localparam int HALF_W       = $clog2(SHIFT_HALVES);
  localparam int BIT_W        = $clog2(CTL_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STROBE
  } state_t;

endpackage

// File: rtl/rtm8sfp_serial_regs_serial_tick_gen.sv
// Free-running divider: one-cycle tick every HALF_PERIOD system clocks.
module serial_tick_gen #(
  parameter int HALF_PERIOD = 500
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(HALF_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rtm8sfp_serial_regs.sv
// Serial bridge refreshing the RTM control chain and reading back the status chain.
// Macro RTM8SFP_SERIAL_REGS_RW_GATE_EN: when defined, sfp_sta_ctl_rw_i gates frame starts.
module rtm8sfp_serial_regs
  import rtm8sfp_serial_regs_pkg::*;
#(
  parameter int g_SYS_CLOCK_FREQ = 100000000,
  parameter int g_SERIAL_FREQ    = 100000
) (
  input  logic             clk_sys_i,
  input  logic             rst_n_i,
  input  logic             sfp_sta_ctl_rw_i,
  output logic             sfp_status_reg_clk_n_o,
  input  logic             sfp_status_reg_out_i,
  output logic             sfp_status_reg_pl_o,
  output logic             sfp_ctl_reg_oe_n_o,
  output logic             sfp_ctl_reg_din_n_o,
  output logic             sfp_ctl_reg_str_n_o,
  output logic [N_SFP-1:0] sfp_led1_o,
  output logic [N_SFP-1:0] sfp_los_o,
  output logic [N_SFP-1:0] sfp_txfault_o,
  output logic [N_SFP-1:0] sfp_detect_n_o,
  input  logic [N_SFP-1:0] sfp_txdisable_i,
  input  logic [N_SFP-1:0] sfp_rs0_i,
  input  logic [N_SFP-1:0] sfp_rs1_i,
  input  logic [N_SFP-1:0] sfp_led1_i,
  input  logic [N_SFP-1:0] sfp_led2_i
);

  localparam int H = g_SYS_CLOCK_FREQ / (2 * g_SERIAL_FREQ);

  if (H < 1) begin : g_bad_half_period
    $error("rtm8sfp_serial_regs: system clock too slow for the serial frequency");
  end

  logic tick;
  logic run_en;

  serial_tick_gen #(
    .HALF_PERIOD(H)
  ) u_tick_gen (
    .clk  (clk_sys_i),
    .rst_n(rst_n_i),
    .tick (tick)
  );

`ifdef RTM8SFP_SERIAL_REGS_RW_GATE_EN
  assign run_en = sfp_sta_ctl_rw_i;
`else
  logic unused_rw;
  assign unused_rw = sfp_sta_ctl_rw_i;
  assign run_en    = 1'b1;
`endif

  state_t                state, state_nxt;
  logic [HALF_W-1:0]     half_cnt, half_nxt;
  logic [BIT_W-1:0]      bit_sel;
  logic [CTL_BITS-1:0]   ctl_q;
  logic [STA_BITS-1:0]   sta_q;
  logic                  capture, sample, done;
  logic                  clk_n_q, pl_q, din_n_q, str_n_q, oe_n_q;
  logic                  clk_n_nxt, pl_nxt, din_n_nxt, str_n_nxt;
  logic [N_SFP-1:0]      led1_q, detect_n_q, txfault_q, los_q;

  // half_cnt counts half bit-periods inside the current state
  always_comb begin
    state_nxt = state;
    half_nxt  = half_cnt;
    capture   = 1'b0;
    sample    = 1'b0;
    done      = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (run_en) begin
            state_nxt = ST_LOAD;
            half_nxt  = '0;
            capture   = 1'b1;
          end
        end
        ST_LOAD: begin
          if (half_cnt == HALF_W'(1)) begin
            state_nxt = ST_SHIFT;
            half_nxt  = '0;
          end else begin
            half_nxt = half_cnt + HALF_W'(1);
          end
        end
        ST_SHIFT: begin
          sample = !half_cnt[0] && (half_cnt[HALF_W-1:1] < BIT_W'(STA_BITS));
          if (half_cnt == HALF_W'(SHIFT_HALVES - 1)) begin
            state_nxt = ST_STROBE;
            half_nxt  = '0;
          end else begin
            half_nxt = half_cnt + HALF_W'(1);
          end
        end
        ST_STROBE: begin
          if (half_cnt == HALF_W'(1)) begin
            state_nxt = ST_IDLE;
            half_nxt  = '0;
            done      = 1'b1;
          end else begin
            half_nxt = half_cnt + HALF_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          half_nxt  = '0;
        end
      endcase
    end

    // Pin levels are decoded from the next state so they leave registers cleanly
    bit_sel   = BIT_W'(CTL_BITS - 1) - half_nxt[HALF_W-1:1];
    pl_nxt    = (state_nxt == ST_LOAD) && (half_nxt == '0);
    clk_n_nxt = !((state_nxt == ST_SHIFT) && half_nxt[0]);
    din_n_nxt = (state_nxt == ST_SHIFT) ? ~ctl_q[bit_sel] : 1'b1;
    str_n_nxt = !((state_nxt == ST_STROBE) && (half_nxt == '0));
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      half_cnt   <= '0;
      ctl_q      <= '0;
      sta_q      <= '0;
      clk_n_q    <= 1'b1;
      pl_q       <= 1'b0;
      din_n_q    <= 1'b1;
      str_n_q    <= 1'b1;
      oe_n_q     <= 1'b1;
      led1_q     <= '0;
      detect_n_q <= '1;
      txfault_q  <= '0;
      los_q      <= '0;
    end else begin
      state    <= state_nxt;
      half_cnt <= half_nxt;
      clk_n_q  <= clk_n_nxt;
      pl_q     <= pl_nxt;
      din_n_q  <= din_n_nxt;
      str_n_q  <= str_n_nxt;
      if (capture) begin
        ctl_q <= {sfp_led2_i, sfp_led1_i, sfp_rs1_i, sfp_rs0_i, sfp_txdisable_i};
      end
      if (sample) begin
        sta_q <= {sta_q[STA_BITS-2:0], sfp_status_reg_out_i};
      end
      if (done) begin
        led1_q     <= sta_q[31:24];
        detect_n_q <= sta_q[23:16];
        txfault_q  <= sta_q[15:8];
        los_q      <= sta_q[7:0];
        oe_n_q     <= 1'b0;
      end
    end
  end

  assign sfp_status_reg_clk_n_o = clk_n_q;
  assign sfp_status_reg_pl_o    = pl_q;
  assign sfp_ctl_reg_din_n_o    = din_n_q;
  assign sfp_ctl_reg_str_n_o    = str_n_q;
  assign sfp_ctl_reg_oe_n_o     = oe_n_q;
  assign sfp_led1_o             = led1_q;
  assign sfp_detect_n_o         = detect_n_q;
  assign sfp_txfault_o          = txfault_q;
  assign sfp_los_o              = los_q;

endmodule

// File: tb/tb_rtm8sfp_serial_regs.sv
// Directed bench for rtm8sfp_serial_regs at a reduced half-period (H = 4).
module tb_rtm8sfp_serial_regs;

  localparam int SYS_F = 800;
  localparam int SER_F = 100;
  localparam int H     = 4;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       rw;
  logic       sta_out;
  logic [7:0] txdis, rs0, rs1, led1_in, led2_in;
  logic       clk_n, pl, oe_n, din_n, str_n;
  logic [7:0] led1, los, txfault, detect_n;

  int errors = 0;
  int checks = 0;

  logic [31:0] pattern;
  logic [31:0] sh;
  logic        clk_n_prev;

  always #5 clk_sys = ~clk_sys;

  rtm8sfp_serial_regs #(
    .g_SYS_CLOCK_FREQ(SYS_F),
    .g_SERIAL_FREQ   (SER_F)
  ) dut (
    .clk_sys_i             (clk_sys),
    .rst_n_i               (rst_n),
    .sfp_sta_ctl_rw_i      (rw),
    .sfp_status_reg_clk_n_o(clk_n),
    .sfp_status_reg_out_i  (sta_out),
    .sfp_status_reg_pl_o   (pl),
    .sfp_ctl_reg_oe_n_o    (oe_n),
    .sfp_ctl_reg_din_n_o   (din_n),
    .sfp_ctl_reg_str_n_o   (str_n),
    .sfp_led1_o            (led1),
    .sfp_los_o             (los),
    .sfp_txfault_o         (txfault),
    .sfp_detect_n_o        (detect_n),
    .sfp_txdisable_i       (txdis),
    .sfp_rs0_i             (rs0),
    .sfp_rs1_i             (rs1),
    .sfp_led1_i            (led1_in),
    .sfp_led2_i            (led2_in)
  );

  function automatic logic [31:0] sta_now();
    return {led1, detect_n, txfault, los};
  endfunction

  // One system clock; also plays the RTM status chain (load on pl, shift on clk_n rise)
  task automatic step();
    @(posedge clk_sys);
    #1;
    if (pl) sh = pattern;
    else if (clk_n && !clk_n_prev) sh = {sh[30:0], 1'b0};
    clk_n_prev = clk_n;
    sta_out    = sh[31];
  endtask

  task automatic set_ctl(input logic [7:0] v);
    txdis = v; rs0 = v; rs1 = v; led1_in = v; led2_in = v;
  endtask

  task automatic run_frame(input logic [39:0] exp_din, input logic [31:0] old_sta,
                           input logic [31:0] new_sta, input logic oe_before,
                           input bit mid_change, input int exp_gap, input string tag);
    int n;
    bit tmo;
    logic [39:0] got;
    tmo = 0;
    n = 0;
    while (!pl && n < 1000) begin step(); n++; end
    if (n >= 1000) tmo = 1;
    if (exp_gap >= 0) begin
      checks++;
      if (n !== exp_gap) begin errors++; $display("FAIL %s pl_gap got=%0d exp=%0d", tag, n, exp_gap); end
    end
    n = 0;
    while (pl && n < 1000) begin step(); n++; end
    checks++;
    if (n !== H) begin errors++; $display("FAIL %s pl_width got=%0d exp=%0d", tag, n, H); end
    got = '0;
    for (int b = 0; b < 40; b++) begin
      n = 0;
      while (clk_n && n < 200) begin step(); n++; end
      if (n >= 200) tmo = 1;
      got[39-b] = din_n;
      if (mid_change && b == 4) set_ctl(8'h55);
      n = 0;
      while (!clk_n && n < 200) begin step(); n++; end
      if (n >= 200) tmo = 1;
    end
    checks++;
    if (got !== exp_din) begin errors++; $display("FAIL %s din_seq got=%h exp=%h", tag, got, exp_din); end
    checks++;
    if (str_n !== 1'b0) begin errors++; $display("FAIL %s str_after_40_bits got=%b exp=0", tag, str_n); end
    checks++;
    if (oe_n !== oe_before || sta_now() !== old_sta) begin
      errors++; $display("FAIL %s strobe_start oe_n=%b sta=%h exp oe_n=%b sta=%h", tag, oe_n, sta_now(), oe_before, old_sta);
    end
    n = 0;
    while (!str_n && n < 1000) begin step(); n++; end
    checks++;
    if (n !== H) begin errors++; $display("FAIL %s str_width got=%0d exp=%0d", tag, n, H); end
    repeat (H - 1) step();
    checks++;
    if (oe_n !== oe_before || sta_now() !== old_sta) begin
      errors++; $display("FAIL %s before_exit oe_n=%b sta=%h exp oe_n=%b sta=%h", tag, oe_n, sta_now(), oe_before, old_sta);
    end
    step();
    checks++;
    if (sta_now() !== new_sta) begin errors++; $display("FAIL %s status got=%h exp=%h", tag, sta_now(), new_sta); end
    checks++;
    if (oe_n !== 1'b0) begin errors++; $display("FAIL %s oe_n_after got=%b exp=0", tag, oe_n); end
    checks++;
    if (tmo) begin errors++; $display("FAIL %s timeout got=1 exp=0", tag); end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; rw = 1'b1; pattern = 32'h0; set_ctl(8'h55);
    repeat (3) step();
    checks++;
    if ({clk_n, pl, din_n, str_n, oe_n} !== 5'b10111) begin
      errors++; $display("FAIL reset_ctl_pins got=%b exp=10111", {clk_n, pl, din_n, str_n, oe_n});
    end
    checks++;
    if (sta_now() !== 32'h00FF_0000) begin errors++; $display("FAIL reset_status got=%h exp=00ff0000", sta_now()); end
    @(negedge clk_sys) rst_n = 1'b1;
    n = 0;
    while (!pl && n < 1000) begin step(); n++; end
    checks++;
    if (n !== H) begin errors++; $display("FAIL reset_first_pl got=%0d exp=%0d", n, H); end
  endtask

  task automatic test_ctl_shift();
    run_frame(40'hAA_AAAA_AAAA, 32'h00FF_0000, 32'h0, 1'b1, 1'b0, 0, "frame_55");
  endtask

  task automatic test_back_to_back();
    txdis = 8'h01; rs0 = 8'h80; rs1 = 8'h00; led1_in = 8'hF0; led2_in = 8'h3C;
    // ctl = 40'h3C_F000_8001, mid-frame change to 8'h55 must wait a frame
    run_frame(40'hC3_0FFF_7FFE, 32'h0, 32'h0, 1'b0, 1'b1, H, "frame_mixed");
    run_frame(40'hAA_AAAA_AAAA, 32'h0, 32'h0, 1'b0, 1'b0, H, "frame_after_change");
  endtask

  task automatic test_status_stable();
    int changes, n;
    changes = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (sta_now() !== 32'h0 || oe_n !== 1'b0) changes++;
    end
    checks++;
    if (changes !== 0) begin errors++; $display("FAIL status_stable changed_cycles=%0d exp=0", changes); end
    n = 0;
    while (str_n && n < 1000) begin step(); n++; end
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL status_stable strobe_wait timeout got=%0d", n); end
    pattern = 32'hA5C3_0F81;
  endtask

  task automatic test_status_pattern();
    run_frame(40'hAA_AAAA_AAAA, 32'h0, 32'hA5C3_0F81, 1'b0, 1'b0, -1, "frame_pattern");
    checks++;
    if (los !== 8'h81) begin errors++; $display("FAIL los got=%h exp=81", los); end
    checks++;
    if (txfault !== 8'h0F) begin errors++; $display("FAIL txfault got=%h exp=0f", txfault); end
    checks++;
    if (detect_n !== 8'hC3) begin errors++; $display("FAIL detect_n got=%h exp=c3", detect_n); end
    checks++;
    if (led1 !== 8'hA5) begin errors++; $display("FAIL led1 got=%h exp=a5", led1); end
  endtask

  task automatic test_reset_mid_shift();
    int n, falls;
    logic prev;
    n = 0; falls = 0; prev = clk_n;
    while (falls < 10 && n < 2000) begin
      step(); n++;
      if (prev && !clk_n) falls++;
      prev = clk_n;
    end
    checks++;
    if (falls !== 10) begin errors++; $display("FAIL midreset_wait falls=%0d exp=10", falls); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_n, pl, din_n, str_n, oe_n} !== 5'b10111) begin
      errors++; $display("FAIL midreset_ctl_pins got=%b exp=10111", {clk_n, pl, din_n, str_n, oe_n});
    end
    checks++;
    if (sta_now() !== 32'h00FF_0000) begin errors++; $display("FAIL midreset_status got=%h exp=00ff0000", sta_now()); end
    repeat (3) step();
    @(negedge clk_sys) rst_n = 1'b1;
    n = 0;
    while (!pl && n < 1000) begin step(); n++; end
    checks++;
    if (n !== H) begin errors++; $display("FAIL midreset_restart got=%0d exp=%0d", n, H); end
  endtask

`ifdef RTM8SFP_SERIAL_REGS_RW_GATE_EN
  task automatic test_rw_gate();
    int act, n;
    @(negedge clk_sys) rst_n = 1'b0;
    rw = 1'b0;
    repeat (2) step();
    @(negedge clk_sys) rst_n = 1'b1;
    act = 0;
    repeat (5 * H) begin step(); if (pl || !clk_n) act++; end
    checks++;
    if (act !== 0) begin errors++; $display("FAIL rw_gate_idle activity=%0d exp=0", act); end
    rw = 1'b1;
    n = 0;
    while (!pl && n < 1000) begin step(); n++; end
    checks++;
    if (n < 1 || n > H) begin errors++; $display("FAIL rw_gate_resume got=%0d exp=1..%0d", n, H); end
  endtask
`endif

  initial begin
    sh = '0; clk_n_prev = 1'b1; sta_out = 1'b0;
    test_reset();
    test_ctl_shift();
    test_back_to_back();
    test_status_stable();
    test_status_pattern();
    test_reset_mid_shift();
`ifdef RTM8SFP_SERIAL_REGS_RW_GATE_EN
    test_rw_gate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
